// File: rtl/regfile_cmd_master_pkg.sv
// Shared definitions for the register-file command master: default widths,
// command opcodes and the sequencer state encoding.
package regfile_cmd_master_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   // Command opcodes as presented on cmd_op
   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_READ2 = 2'b01,
      OP_COPY  = 2'b10,
      OP_SWAP  = 2'b11
   } cmd_op_e;

   // Sequencer states; every state other than ST_IDLE means a command is in flight
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR     = 3'd1,
      ST_RD     = 3'd2,
      ST_CP_WR  = 3'd3,
      ST_SW_WR1 = 3'd4,
      ST_SW_WR2 = 3'd5,
      ST_RESP   = 3'd6
   } state_e;

   // Where a command goes once its source operands have been read
   function automatic state_e after_read_state(input cmd_op_e op);
      state_e nxt;
      case (op)
         OP_READ2: nxt = ST_RESP;
         OP_COPY:  nxt = ST_CP_WR;
         OP_SWAP:  nxt = ST_SW_WR1;
         default:  nxt = ST_IDLE;
      endcase
      return nxt;
   endfunction

   // WRITE needs no read phase; everything else reads first
   function automatic state_e accept_state(input cmd_op_e op);
      return (op == OP_WRITE) ? ST_WR : ST_RD;
   endfunction

endpackage

// File: rtl/regfile_cmd_master.sv
// Register-file command master. Accepts one WRITE/READ2/COPY/SWAP command at
// a time and sequences it into register-file port cycles. All rf_* and rsp_*
// outputs come straight from flops; their next values are derived from the
// next state so that each port cycle lines up exactly with its FSM state.
module regfile_cmd_master
   import regfile_cmd_master_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data1,
   output logic [DATA_W-1:0] rsp_data2,
   output logic              rf_regWrite,
   output logic [ADDR_W-1:0] rf_writeReg,
   output logic [DATA_W-1:0] rf_writeData,
   output logic [ADDR_W-1:0] rf_readReg1,
   output logic [ADDR_W-1:0] rf_readReg2,
   input  logic [DATA_W-1:0] rf_readData1,
   input  logic [DATA_W-1:0] rf_readData2,
   output logic              busy
);

   state_e              state_q, state_d;

   // Latched command fields
   cmd_op_e             op_q, op_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic [ADDR_W-1:0]   rs1_q, rs1_d;
   logic [ADDR_W-1:0]   rs2_q, rs2_d;
   logic [DATA_W-1:0]   wval_q, wval_d;

   // Operand values captured at the end of the read cycle
   logic [DATA_W-1:0]   data1_q, data1_d;
   logic [DATA_W-1:0]   data2_q, data2_d;

   // Registered port outputs
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   wreg_q, wreg_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [ADDR_W-1:0]   rreg1_q, rreg1_d;
   logic [ADDR_W-1:0]   rreg2_q, rreg2_d;
   logic                rsp_valid_q, rsp_valid_d;

   // Only IDLE accepts, and never while reset is held
   assign cmd_ready = (state_q == ST_IDLE) && reset;
   assign busy      = (state_q != ST_IDLE);

   assign rsp_valid    = rsp_valid_q;
   assign rsp_data1    = data1_q;
   assign rsp_data2    = data2_q;
   assign rf_regWrite  = we_q;
   assign rf_writeReg  = wreg_q;
   assign rf_writeData = wdata_q;
   assign rf_readReg1  = rreg1_q;
   assign rf_readReg2  = rreg2_q;

   // Next-state, command latching and next values of the registered outputs
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rd_d        = rd_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      wval_d      = wval_q;
      data1_d     = data1_q;
      data2_d     = data2_q;
      we_d        = 1'b0;
      wreg_d      = '0;
      wdata_d     = '0;
      rreg1_d     = rreg1_q;
      rreg2_d     = rreg2_q;
      rsp_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               op_d    = cmd_op_e'(cmd_op);
               rd_d    = cmd_rd;
               rs1_d   = cmd_rs1;
               rs2_d   = cmd_rs2;
               wval_d  = cmd_wdata;
               state_d = accept_state(cmd_op_e'(cmd_op));
            end
         end
         ST_WR:     state_d = ST_IDLE;
         ST_RD: begin
            // Read data is combinational from the indices driven this cycle
            data1_d = rf_readData1;
            data2_d = rf_readData2;
            state_d = after_read_state(op_q);
         end
         ST_CP_WR:  state_d = ST_IDLE;
         ST_SW_WR1: state_d = ST_SW_WR2;
         ST_SW_WR2: state_d = ST_IDLE;
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default:   state_d = ST_IDLE;
      endcase

      // Port values for the cycle spent in state_d. The _d field copies are
      // used because fields and operands may be updating on this same edge.
      case (state_d)
         ST_WR: begin
            we_d    = 1'b1;
            wreg_d  = rd_d;
            wdata_d = wval_d;
         end
         ST_RD: begin
            rreg1_d = rs1_d;
            rreg2_d = rs2_d;
         end
         ST_CP_WR: begin
            we_d    = 1'b1;
            wreg_d  = rd_d;
            wdata_d = data1_d;
         end
         ST_SW_WR1: begin
            we_d    = 1'b1;
            wreg_d  = rs1_d;
            wdata_d = data2_d;
         end
         ST_SW_WR2: begin
            we_d    = 1'b1;
            wreg_d  = rs2_d;
            wdata_d = data1_d;
         end
         ST_RESP:   rsp_valid_d = 1'b1;
         default:   ;
      endcase
   end

   // State, command fields and output registers; reset aborts any command
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_WRITE;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         wval_q      <= '0;
         data1_q     <= '0;
         data2_q     <= '0;
         we_q        <= 1'b0;
         wreg_q      <= '0;
         wdata_q     <= '0;
         rreg1_q     <= '0;
         rreg2_q     <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         wval_q      <= wval_d;
         data1_q     <= data1_d;
         data2_q     <= data2_d;
         we_q        <= we_d;
         wreg_q      <= wreg_d;
         wdata_q     <= wdata_d;
         rreg1_q     <= rreg1_d;
         rreg2_q     <= rreg2_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Directed bench for regfile_cmd_master driving a behavioural 32x32 register file.
module tb_regfile_cmd_master;
   import regfile_cmd_master_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_data1, rsp_data2;
   logic          rf_regWrite;
   logic [AW-1:0] rf_writeReg, rf_readReg1, rf_readReg2;
   logic [DW-1:0] rf_writeData, rf_readData1, rf_readData2;
   logic          busy;

   logic [DW-1:0] mem [32];
   int            wr_count;
   int            n_assert;
   int            n_fail;
   int            c0;

   regfile_cmd_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
      .rf_regWrite(rf_regWrite), .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
      .rf_readReg1(rf_readReg1), .rf_readReg2(rf_readReg2),
      .rf_readData1(rf_readData1), .rf_readData2(rf_readData2),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: combinational read, write on rising edge, not reset
   assign rf_readData1 = mem[rf_readReg1];
   assign rf_readData2 = mem[rf_readReg2];
   always @(posedge clk) begin
      if (rf_regWrite) begin
         mem[rf_writeReg] <= rf_writeData;
         wr_count         <= wr_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command, wait (bounded) for ready, return just after the accepting edge
   task automatic send_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] wd);
      cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_wdata = wd;
      for (int i = 0; i < 20 && !cmd_ready; i++) tick();
      check("cmd_ready_before_accept", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      $display("cmd op=%0d rd=%0d rs1=%0d rs2=%0d wdata=%h accepted at %0t", op, rd, rs1, rs2, wd, $time);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && busy; i++) tick();
      check("return_to_idle", busy, 0);
   endtask

   task automatic do_write(input logic [4:0] rd, input logic [31:0] wd);
      send_cmd(OP_WRITE, rd, 5'd0, 5'd0, wd);
      wait_idle();
   endtask

   // READ2 with rsp_ready held high: response must last exactly one cycle
   task automatic do_read2(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] e1, input logic [31:0] e2);
      rsp_ready = 1'b1;
      send_cmd(OP_READ2, 5'd0, rs1, rs2, 32'd0);
      for (int i = 0; i < 20 && !rsp_valid; i++) tick();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data1", rsp_data1, e1);
      check("rsp_data2", rsp_data2, e2);
      $display("rsp rs1=%0d rs2=%0d data1=%h data2=%h", rs1, rs2, rsp_data1, rsp_data2);
      tick();
      check("rsp_one_cycle", rsp_valid, 0);
      check("idle_after_rsp", busy, 0);
   endtask

   initial begin
      n_assert = 0; n_fail = 0; wr_count = 0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rd = '0; cmd_rs1 = '0;
      cmd_rs2 = '0; cmd_wdata = '0; rsp_ready = 1'b1;

      // Reset held for two cycles
      tick();
      check("cmd_ready_in_reset", cmd_ready, 0);
      tick();
      check("cmd_ready_in_reset2", cmd_ready, 0);
      reset = 1'b1;
      tick();
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data1", rsp_data1, 0);
      check("rst_rsp_data2", rsp_data2, 0);
      check("rst_regWrite", rf_regWrite, 0);
      check("rst_writeReg", rf_writeReg, 0);
      check("rst_writeData", rf_writeData, 0);
      check("rst_readReg1", rf_readReg1, 0);
      check("rst_readReg2", rf_readReg2, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 1);

      // WRITE r1: port cycle follows the accepting edge, lands at the edge after
      send_cmd(OP_WRITE, 5'd1, 5'd0, 5'd0, 32'h12345678);
      check("wr_regWrite", rf_regWrite, 1);
      check("wr_writeReg", rf_writeReg, 1);
      check("wr_writeData", rf_writeData, 32'h12345678);
      check("wr_busy", busy, 1);
      check("wr_cmd_ready", cmd_ready, 0);
      tick();
      check("wr_mem1", mem[1], 32'h12345678);
      check("wr_regWrite_off", rf_regWrite, 0);
      check("wr_cmd_ready_back", cmd_ready, 1);
      do_read2(5'd1, 5'd0, 32'h12345678, 32'h00000000);

      // COPY r3 -> r7
      do_write(5'd3, 32'habcdefab);
      c0 = wr_count;
      send_cmd(OP_COPY, 5'd7, 5'd3, 5'd0, 32'd0);
      wait_idle();
      check("copy_pulses", wr_count - c0, 1);
      do_read2(5'd7, 5'd3, 32'habcdefab, 32'habcdefab);

      // SWAP r4 <-> r5
      do_write(5'd4, 32'h8765abcd);
      do_write(5'd5, 32'ha1b2c3d4);
      c0 = wr_count;
      send_cmd(OP_SWAP, 5'd0, 5'd4, 5'd5, 32'd0);
      wait_idle();
      check("swap_pulses", wr_count - c0, 2);
      do_read2(5'd4, 5'd5, 32'ha1b2c3d4, 32'h8765abcd);

      // SWAP with rs1==rs2 leaves the register unchanged; index 0 readable as normal
      c0 = wr_count;
      send_cmd(OP_SWAP, 5'd0, 5'd3, 5'd3, 32'd0);
      wait_idle();
      check("swap_same_pulses", wr_count - c0, 2);
      do_read2(5'd3, 5'd0, 32'habcdefab, 32'h00000000);

      // Stalled response with a competing command that must be ignored
      rsp_ready = 1'b0;
      send_cmd(OP_READ2, 5'd0, 5'd1, 5'd3, 32'd0);
      for (int i = 0; i < 20 && !rsp_valid; i++) tick();
      c0 = wr_count;
      cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_rd = 5'd9; cmd_wdata = 32'hdeadbeef;
      for (int i = 0; i < 5; i++) begin
         check("stall_rsp_valid", rsp_valid, 1);
         check("stall_data1", rsp_data1, 32'h12345678);
         check("stall_data2", rsp_data2, 32'habcdefab);
         check("stall_cmd_ready", cmd_ready, 0);
         $display("stall cycle %0d rsp_valid=%b data1=%h data2=%h", i, rsp_valid, rsp_data1, rsp_data2);
         tick();
      end
      check("stall_no_write", wr_count - c0, 0);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      check("stall_release_valid", rsp_valid, 0);
      check("stall_release_idle", busy, 0);
      check("stall_r9_untouched", mem[9], 32'h0);

      // SWAP r4/r5 aborted by reset during SW_WR1
      c0 = wr_count;
      send_cmd(OP_SWAP, 5'd0, 5'd4, 5'd5, 32'd0);
      tick();
      check("abort_sw1_regWrite", rf_regWrite, 1);
      check("abort_sw1_writeReg", rf_writeReg, 4);
      reset = 1'b0;
      tick();
      check("abort_regWrite", rf_regWrite, 0);
      check("abort_busy", busy, 0);
      check("abort_cmd_ready", cmd_ready, 0);
      tick();
      reset = 1'b1;
      tick();
      tick();
      check("abort_pulses", wr_count - c0, 1);
      do_read2(5'd4, 5'd5, 32'h8765abcd, 32'h8765abcd);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
